// File: rtl/stw_count_core.sv
// ============================================================================
// stw_count_core
// ----------------------------------------------------------------------------
// Stopwatch timing core. Holds a four-digit BCD count (mm:ss) and the
// control FSM (IDLE / RUN / PAUSE / LAP) that decides when the count
// advances and when the downstream per-digit freeze stage holds the display.
//
// Optional feature macro: STW_SATURATE_EN
//   undefined (default) : the count wraps from max to 00:00 and pulses wrap.
//   defined             : the count holds at max, wrap stays 0, and the FSM
//                         drops from RUN/LAP to PAUSE on that tick.
//
// Parameters:
//   MIN_TENS_MAX  maximum minute-tens digit before wrap (1..9)
//   SEC_TENS_MAX  maximum second-tens digit before wrap (5)
//
// Ports:
//   clk         system clock
//   reset       asynchronous, active-low reset
//   tick_en     one-clk strobe, advances the count by one second
//   start_stop  one-clk pulse, start/pause toggle
//   lap_reset   one-clk pulse, lap when running, clear when paused
//   sec0/sec1   BCD seconds ones / tens
//   min0/min1   BCD minutes ones / tens
//   freeze_en   display hold request, high only in LAP
//   running     high in RUN or LAP
//   wrap        one-clk pulse after the count rolls over to 00:00
//
// Button semantics: start_stop and lap_reset are single-cycle pulses sampled
// on the rising clock edge. When both are high in the same cycle,
// start_stop wins and lap_reset is dropped.
// ============================================================================
module stw_count_core #(
    parameter int MIN_TENS_MAX = 5,
    parameter int SEC_TENS_MAX = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick_en,
    input  logic       start_stop,
    input  logic       lap_reset,
    output logic [3:0] sec0,
    output logic [3:0] sec1,
    output logic [3:0] min0,
    output logic [3:0] min1,
    output logic       freeze_en,
    output logic       running,
    output logic       wrap
);

    localparam logic [3:0] MIN_MAX = 4'(MIN_TENS_MAX);
    localparam logic [3:0] SEC_MAX = 4'(SEC_TENS_MAX);
    localparam logic [3:0] ONES_MAX = 4'd9;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        LAP   = 2'd3
    } state_t;

    // State register; left as a plainly named typed signal so checkers and
    // debug probes can observe it directly.
    state_t state;

    // ------------------------------------------------------------------------
    // Next-state and next-count decode
    // ------------------------------------------------------------------------
    logic       count_en;
    logic       at_max;
    logic       saturate;
    logic       clear;
    state_t     state_next;
    logic [3:0] sec0_inc;
    logic [3:0] sec1_inc;
    logic [3:0] min0_inc;
    logic [3:0] min1_inc;
    logic       carry_s0;
    logic       carry_s1;
    logic       carry_m0;

    // Counting depends only on the pre-edge state, so a tick alongside a
    // start pulse from IDLE/PAUSE is dropped while a tick alongside a stop
    // pulse in RUN is still counted.
    assign count_en = tick_en && ((state == RUN) || (state == LAP));

    assign at_max = (sec0 == ONES_MAX) && (sec1 == SEC_MAX) &&
                    (min0 == ONES_MAX) && (min1 == MIN_MAX);

`ifdef STW_SATURATE_EN
    assign saturate = count_en && at_max;
`else
    assign saturate = 1'b0;
`endif

    // Clear happens only on a lone lap_reset while paused.
    assign clear = (state == PAUSE) && lap_reset && !start_stop;

    // Ripple carry chain across the four BCD digits. At full max every
    // digit rolls to 0, which is exactly the wrap to 00:00.
    always_comb begin
        carry_s0 = (sec0 == ONES_MAX);
        carry_s1 = carry_s0 && (sec1 == SEC_MAX);
        carry_m0 = carry_s1 && (min0 == ONES_MAX);

        sec0_inc = carry_s0 ? 4'd0 : sec0 + 4'd1;

        sec1_inc = sec1;
        if (carry_s0) begin
            sec1_inc = (sec1 == SEC_MAX) ? 4'd0 : sec1 + 4'd1;
        end

        min0_inc = min0;
        if (carry_s1) begin
            min0_inc = (min0 == ONES_MAX) ? 4'd0 : min0 + 4'd1;
        end

        min1_inc = min1;
        if (carry_m0) begin
            min1_inc = (min1 == MIN_MAX) ? 4'd0 : min1 + 4'd1;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start_stop) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (start_stop) begin
                    state_next = PAUSE;
                end else if (lap_reset) begin
                    state_next = LAP;
                end
            end
            LAP: begin
                if (start_stop) begin
                    state_next = PAUSE;
                end else if (lap_reset) begin
                    state_next = RUN;
                end
            end
            PAUSE: begin
                if (start_stop) begin
                    state_next = RUN;
                end else if (lap_reset) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase

        // Hitting max with saturation enabled always stops the watch,
        // overriding any button pulse in the same cycle.
        if (saturate) begin
            state_next = PAUSE;
        end
    end

    // ------------------------------------------------------------------------
    // State, digit and wrap registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            sec0  <= 4'd0;
            sec1  <= 4'd0;
            min0  <= 4'd0;
            min1  <= 4'd0;
            wrap  <= 1'b0;
        end else begin
            state <= state_next;
            wrap  <= 1'b0;

            if (clear) begin
                sec0 <= 4'd0;
                sec1 <= 4'd0;
                min0 <= 4'd0;
                min1 <= 4'd0;
            end else if (count_en && !saturate) begin
                sec0 <= sec0_inc;
                sec1 <= sec1_inc;
                min0 <= min0_inc;
                min1 <= min1_inc;
                wrap <= at_max;
            end
        end
    end

    // Decoded straight from the state register so the freeze stage and
    // running indicator change on the same edge as the state itself and
    // fall immediately with the asynchronous reset.
    assign freeze_en = (state == LAP);
    assign running   = (state == RUN) || (state == LAP);

endmodule

// File: tb/tb_stw_count_core.sv
// ============================================================================
// tb_stw_count_core
// ----------------------------------------------------------------------------
// Directed bench for stw_count_core. Inputs change 1 ns after a rising edge
// and outputs are sampled at that same point, so each drive() call covers
// exactly one DUT clock edge. Expected values are hand-computed constants.
// Digits are compared as one 16-bit word {min1,min0,sec1,sec0}, which reads
// as mm:ss in hex.
// ============================================================================
module tb_stw_count_core;

    logic       clk;
    logic       reset;
    logic       tick_en;
    logic       start_stop;
    logic       lap_reset;
    logic [3:0] sec0;
    logic [3:0] sec1;
    logic [3:0] min0;
    logic [3:0] min1;
    logic       freeze_en;
    logic       running;
    logic       wrap;

    int n_cmp;
    int n_fail;

    stw_count_core #(
        .MIN_TENS_MAX(5),
        .SEC_TENS_MAX(5)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .tick_en   (tick_en),
        .start_stop(start_stop),
        .lap_reset (lap_reset),
        .sec0      (sec0),
        .sec1      (sec1),
        .min0      (min0),
        .min1      (min1),
        .freeze_en (freeze_en),
        .running   (running),
        .wrap      (wrap)
    );

    // ------------------------------------------------------------------------
    // Clock
    // ------------------------------------------------------------------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------------
    // Driver tasks
    // ------------------------------------------------------------------------
    task automatic drive(input logic ss, input logic lr, input logic tk);
        start_stop = ss;
        lap_reset  = lr;
        tick_en    = tk;
        @(posedge clk);
        #1;
        start_stop = 1'b0;
        lap_reset  = 1'b0;
        tick_en    = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            drive(1'b0, 1'b0, 1'b1);
        end
    endtask

    // ------------------------------------------------------------------------
    // Scenarios
    // ------------------------------------------------------------------------
    task automatic test_reset;
        reset = 1'b0;
        #3;
        n_cmp++;
        if ({min1, min0, sec1, sec0} !== 16'h0000) begin
            n_fail++;
            $display("FAIL reset_digits got %h exp %h", {min1, min0, sec1, sec0}, 16'h0000);
        end
        n_cmp++;
        if ({freeze_en, running, wrap} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_flags got %b exp %b", {freeze_en, running, wrap}, 3'b000);
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_count_75;
        drive(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 75; i++) begin
            drive(1'b0, 1'b0, 1'b1);
            if (i % 4 == 0) drive(1'b0, 1'b0, 1'b0);
        end
        n_cmp++;
        if ({min1, min0, sec1, sec0} !== 16'h0115) begin
            n_fail++;
            $display("FAIL count75_digits got %h exp %h", {min1, min0, sec1, sec0}, 16'h0115);
        end
        n_cmp++;
        if ({freeze_en, running, wrap} !== 3'b010) begin
            n_fail++;
            $display("FAIL count75_flags got %b exp %b", {freeze_en, running, wrap}, 3'b010);
        end
        drive(1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b0);
        n_cmp++;
        if ({min1, min0, sec1, sec0, running} !== 17'h00000) begin
            n_fail++;
            $display("FAIL count75_clear got %h exp %h", {min1, min0, sec1, sec0, running}, 17'h00000);
        end
    endtask

    task automatic test_lap;
        drive(1'b1, 1'b0, 1'b0);
        ticks(10);
        drive(1'b0, 1'b1, 1'b0);
        n_cmp++;
        if ({freeze_en, running} !== 2'b11 || {min1, min0, sec1, sec0} !== 16'h0010) begin
            n_fail++;
            $display("FAIL lap_enter got fr/run=%b digits=%h exp 11 0010",
                     {freeze_en, running}, {min1, min0, sec1, sec0});
        end
        ticks(5);
        n_cmp++;
        if ({min1, min0, sec1, sec0} !== 16'h0015 || freeze_en !== 1'b1) begin
            n_fail++;
            $display("FAIL lap_counting got digits=%h fr=%b exp 0015 1",
                     {min1, min0, sec1, sec0}, freeze_en);
        end
        drive(1'b0, 1'b1, 1'b0);
        n_cmp++;
        if ({freeze_en, running} !== 2'b01) begin
            n_fail++;
            $display("FAIL lap_exit got %b exp %b", {freeze_en, running}, 2'b01);
        end
        // LAP + start_stop -> PAUSE shows the live count
        drive(1'b0, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 1'b0);
        n_cmp++;
        if ({freeze_en, running} !== 2'b00 || {min1, min0, sec1, sec0} !== 16'h0015) begin
            n_fail++;
            $display("FAIL lap_to_pause got fr/run=%b digits=%h exp 00 0015",
                     {freeze_en, running}, {min1, min0, sec1, sec0});
        end
        drive(1'b0, 1'b1, 1'b0);
        n_cmp++;
        if ({min1, min0, sec1, sec0} !== 16'h0000) begin
            n_fail++;
            $display("FAIL pause_clear got %h exp %h", {min1, min0, sec1, sec0}, 16'h0000);
        end
        // IDLE ignores lap_reset and ticks
        drive(1'b0, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 1'b1);
        n_cmp++;
        if ({min1, min0, sec1, sec0} !== 16'h0000 || {freeze_en, running} !== 2'b00) begin
            n_fail++;
            $display("FAIL idle_ignore got digits=%h fr/run=%b exp 0000 00",
                     {min1, min0, sec1, sec0}, {freeze_en, running});
        end
    endtask

    task automatic test_both_pressed;
        drive(1'b1, 1'b0, 1'b0);
        ticks(3);
        drive(1'b1, 1'b1, 1'b0);
        n_cmp++;
        if ({freeze_en, running} !== 2'b00 || {min1, min0, sec1, sec0} !== 16'h0003) begin
            n_fail++;
            $display("FAIL both_to_pause got fr/run=%b digits=%h exp 00 0003",
                     {freeze_en, running}, {min1, min0, sec1, sec0});
        end
        drive(1'b0, 1'b1, 1'b0);
        n_cmp++;
        if ({min1, min0, sec1, sec0} !== 16'h0000 || running !== 1'b0) begin
            n_fail++;
            $display("FAIL both_then_clear got digits=%h run=%b exp 0000 0",
                     {min1, min0, sec1, sec0}, running);
        end
    endtask

    task automatic test_start_tick;
        drive(1'b1, 1'b0, 1'b1);
        n_cmp++;
        if ({min1, min0, sec1, sec0} !== 16'h0000 || running !== 1'b1) begin
            n_fail++;
            $display("FAIL start_tick_idle got digits=%h run=%b exp 0000 1",
                     {min1, min0, sec1, sec0}, running);
        end
        ticks(7);
        drive(1'b1, 1'b0, 1'b1);
        n_cmp++;
        if ({min1, min0, sec1, sec0} !== 16'h0008 || running !== 1'b0) begin
            n_fail++;
            $display("FAIL stop_tick_run got digits=%h run=%b exp 0008 0",
                     {min1, min0, sec1, sec0}, running);
        end
        drive(1'b0, 1'b0, 1'b1);
        drive(1'b1, 1'b0, 1'b1);
        n_cmp++;
        if ({min1, min0, sec1, sec0} !== 16'h0008) begin
            n_fail++;
            $display("FAIL pause_resume_tick got %h exp %h", {min1, min0, sec1, sec0}, 16'h0008);
        end
        ticks(1);
        n_cmp++;
        if ({min1, min0, sec1, sec0} !== 16'h0009) begin
            n_fail++;
            $display("FAIL resume_count got %h exp %h", {min1, min0, sec1, sec0}, 16'h0009);
        end
        drive(1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_wrap;
        drive(1'b1, 1'b0, 1'b0);
        ticks(599);
        n_cmp++;
        if ({min1, min0, sec1, sec0} !== 16'h0959) begin
            n_fail++;
            $display("FAIL carry_0959 got %h exp %h", {min1, min0, sec1, sec0}, 16'h0959);
        end
        ticks(1);
        n_cmp++;
        if ({min1, min0, sec1, sec0} !== 16'h1000) begin
            n_fail++;
            $display("FAIL carry_1000 got %h exp %h", {min1, min0, sec1, sec0}, 16'h1000);
        end
        ticks(2999);
        n_cmp++;
        if ({min1, min0, sec1, sec0} !== 16'h5959 || wrap !== 1'b0) begin
            n_fail++;
            $display("FAIL at_max got digits=%h wrap=%b exp 5959 0",
                     {min1, min0, sec1, sec0}, wrap);
        end
        ticks(1);
`ifdef STW_SATURATE_EN
        n_cmp++;
        if ({min1, min0, sec1, sec0} !== 16'h5959 || {wrap, running, freeze_en} !== 3'b000) begin
            n_fail++;
            $display("FAIL saturate got digits=%h wrap/run/fr=%b exp 5959 000",
                     {min1, min0, sec1, sec0}, {wrap, running, freeze_en});
        end
        drive(1'b0, 1'b1, 1'b0);
`else
        n_cmp++;
        if ({min1, min0, sec1, sec0} !== 16'h0000 || wrap !== 1'b1) begin
            n_fail++;
            $display("FAIL wrap_edge got digits=%h wrap=%b exp 0000 1",
                     {min1, min0, sec1, sec0}, wrap);
        end
        drive(1'b0, 1'b0, 1'b0);
        n_cmp++;
        if (wrap !== 1'b0 || running !== 1'b1) begin
            n_fail++;
            $display("FAIL wrap_pulse_len got wrap=%b run=%b exp 0 1", wrap, running);
        end
        drive(1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b0);
`endif
        n_cmp++;
        if ({min1, min0, sec1, sec0, running} !== 17'h00000) begin
            n_fail++;
            $display("FAIL wrap_cleanup got %h exp %h", {min1, min0, sec1, sec0, running}, 17'h00000);
        end
    endtask

    task automatic test_async_reset;
        drive(1'b1, 1'b0, 1'b0);
        ticks(222);
        drive(1'b0, 1'b1, 1'b0);
        n_cmp++;
        if ({min1, min0, sec1, sec0} !== 16'h0342 || freeze_en !== 1'b1) begin
            n_fail++;
            $display("FAIL pre_reset_lap got digits=%h fr=%b exp 0342 1",
                     {min1, min0, sec1, sec0}, freeze_en);
        end
        // Assert reset between clock edges and look before the next edge.
        #2;
        reset = 1'b0;
        #1;
        n_cmp++;
        if ({min1, min0, sec1, sec0} !== 16'h0000 || {freeze_en, running, wrap} !== 3'b000) begin
            n_fail++;
            $display("FAIL async_reset got digits=%h fr/run/wrap=%b exp 0000 000",
                     {min1, min0, sec1, sec0}, {freeze_en, running, wrap});
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b1);
        n_cmp++;
        if ({min1, min0, sec1, sec0} !== 16'h0000 || running !== 1'b0) begin
            n_fail++;
            $display("FAIL post_reset_idle got digits=%h run=%b exp 0000 0",
                     {min1, min0, sec1, sec0}, running);
        end
    endtask

    // ------------------------------------------------------------------------
    // Sequence and report
    // ------------------------------------------------------------------------
    initial begin
        n_cmp      = 0;
        n_fail     = 0;
        reset      = 1'b0;
        tick_en    = 1'b0;
        start_stop = 1'b0;
        lap_reset  = 1'b0;

        test_reset();
        test_count_75();
        test_lap();
        test_both_pressed();
        test_start_tick();
        test_wrap();
        test_async_reset();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/stw_count_core.md
Name: stw_count_core

Overview:
- Stopwatch timing core: holds four BCD digits (mm:ss) and a control FSM (idle/run/pause/lap).
- Sits directly upstream of the per-digit freeze stage. Each digit output feeds one freeze-stage data input; freeze_en drives that stage's freeze input.
- Buttons arrive as debounced one-pulses. Counting advances on an external 1 Hz tick_en strobe.

Parameters:
- MIN_TENS_MAX, 5, maximum value of the minute-tens digit before wrap (range 1..9).
- SEC_TENS_MAX, 5, maximum value of the second-tens digit before wrap (fixed use: 5).

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-low reset
- tick_en  input  1  one-clk strobe, advances the count by one second
- start_stop  input  1  one-clk pulse, start/pause toggle
- lap_reset  input  1  one-clk pulse, lap when running, clear when paused
- sec0  output  4  BCD seconds ones
- sec1  output  4  BCD seconds tens
- min0  output  4  BCD minutes ones
- min1  output  4  BCD minutes tens
- freeze_en  output  1  display hold request to the downstream freeze stage
- running  output  1  high in RUN or LAP
- wrap  output  1  one-clk pulse when the count rolls over from max to 00:00

Behaviour:
- Reset (async, reset=0): all digits 0, state IDLE, freeze_en 0, running 0, wrap 0. Applies immediately, including mid-count and in LAP.
- All outputs are registered. freeze_en and running are decoded from the state register, not the next state.
- FSM states: IDLE, RUN, PAUSE, LAP.
- Transitions:
  - IDLE + start_stop -> RUN.
  - IDLE + lap_reset -> IDLE (no effect).
  - RUN + start_stop -> PAUSE.
  - RUN + lap_reset -> LAP.
  - LAP + start_stop -> PAUSE; freeze_en drops, so the display shows the live count.
  - LAP + lap_reset -> RUN.
  - PAUSE + start_stop -> RUN.
  - PAUSE + lap_reset -> IDLE; all digits clear to 0 on the same edge.
- If start_stop and lap_reset are both high in one cycle, start_stop wins and lap_reset is ignored.
- freeze_en = 1 only in LAP.
- Counting:
  - The count advances on an edge where tick_en=1 and the current (pre-edge) state is RUN or LAP.
  - A tick in the same cycle as a start pulse from IDLE/PAUSE is not counted.
  - A tick in the same cycle as a stop pulse in RUN is counted.
- Carry chain:
  - sec0 9->0 carries into sec1.
  - sec1 SEC_TENS_MAX->0 carries into min0.
  - min0 9->0 carries into min1.
  - min1 MIN_TENS_MAX->0 with all lower digits at max = wrap to 00:00. wrap=1 for exactly the clock cycle after that edge.
- Digits never hold non-BCD values. Count latency: one clk from the tick_en sample to the digit update.
- IDLE clear and reset are the only ways to return to 00:00 other than wrap.

Optional Feature:
- Macro STW_SATURATE_EN.
- Defined:
  - At max count (e.g. 59:59), a tick does not wrap. Digits hold at max, wrap stays 0, and the FSM moves to PAUSE (RUN or LAP -> PAUSE) on that edge, so freeze_en drops.
  - lap_reset then clears to IDLE as usual.
- Undefined: wrap-around behaviour as above.

Test Plan:
- Reset, then start_stop, then 75 tick_en strobes -> sec0=5, sec1=1, min0=1, min1=0, running=1, freeze_en=0.
- From 00:10 in RUN: lap_reset, then 5 ticks -> freeze_en=1 the cycle after the pulse and digits reach 00:15. Second lap_reset -> freeze_en=0, state RUN.
- Counting at 59:59 with one tick -> next cycle 00:00 and wrap=1 for one cycle. With STW_SATURATE_EN: digits stay 59:59, wrap=0, running=0.
- start_stop and lap_reset high together in RUN -> PAUSE, freeze_en=0. Then lap_reset alone -> all digits 0, IDLE.
- start_stop coincident with tick_en from IDLE -> count stays 00:00. start_stop coincident with tick_en in RUN at 00:07 -> 00:08, PAUSE.
- Assert reset mid-LAP at 03:42 -> outputs immediately 00:00, freeze_en=0, running=0, without waiting for clk.
